// File: rtl/inst_mem_server_if.sv
// Fetch and byte-loader signal bundle between the core/loader side (master) and inst_mem_server (slave).
interface inst_mem_server_if #(
   parameter int DEPTH_LOG2 = 10
);
   logic [63:0]         inst_addr;
   logic                inst_ena;
   logic [31:0]         inst;
   logic                ld_start;
   logic                ld_valid;
   logic [7:0]          ld_byte;
   logic                ld_last;
   logic                ld_ready;
   logic                ld_done;
   logic [DEPTH_LOG2:0] words_loaded;
   logic                overflow;
   logic                fetch_err;
   logic                cpu_hold;

   modport master (
      output inst_addr, inst_ena, ld_start, ld_valid, ld_byte, ld_last,
      input  inst, ld_ready, ld_done, words_loaded, overflow, fetch_err, cpu_hold
   );

   modport slave (
      input  inst_addr, inst_ena, ld_start, ld_valid, ld_byte, ld_last,
      output inst, ld_ready, ld_done, words_loaded, overflow, fetch_err, cpu_hold
   );
endinterface

// File: rtl/inst_mem_server.sv
// Instruction memory: byte-serial little-endian loader fills a word array, fetch is served combinationally (0 cycles).
// Loader is never stalled in LOAD (ld_ready=1 even when full; excess bytes are dropped and flagged).
module inst_mem_server #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
   input logic              clk,
   input logic              rst,
   inst_mem_server_if.slave bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;

   logic [1:0]            r_state;
   logic [1:0]            r_byte_cnt;
   logic [23:0]           r_asm;
   logic [DEPTH_LOG2:0]   r_wptr;
   logic                  r_done;
   logic                  r_overflow;
   logic                  r_fetch_err;
   logic [31:0]           r_mem [DEPTH];

   logic                  w_load;
   logic                  w_run;
   logic                  w_acc;
   logic                  w_full;
   logic                  w_wr;
   logic [31:0]           w_word;
   logic [DEPTH_LOG2-1:0] w_waddr;
   logic                  w_aligned;
   logic                  w_in_range;
   logic                  w_served;
   logic [DEPTH_LOG2-1:0] w_raddr;

   assign w_load  = (r_state == S_LOAD);
   assign w_run   = (r_state == S_RUN);
   // A restart in the same cycle wins over the byte.
   assign w_acc   = w_load && bus.ld_valid && !bus.ld_start;
   // Pointer only reaches DEPTH when every word is written, so the MSB alone means full.
   assign w_full  = r_wptr[DEPTH_LOG2];
   assign w_wr    = w_acc && !w_full && (bus.ld_last || (r_byte_cnt == 2'd3));
   // Lanes above byte_cnt are held at zero, so a partial word has clean upper lanes.
   assign w_word  = {8'h00, r_asm} | ({24'h00_0000, bus.ld_byte} << {r_byte_cnt, 3'b000});
   assign w_waddr = r_wptr[DEPTH_LOG2-1:0];

   assign w_aligned  = (bus.inst_addr[1:0] == 2'b00);
   assign w_in_range = (bus.inst_addr[63:DEPTH_LOG2+2] == '0);
   assign w_served   = w_run && bus.inst_ena && w_aligned && w_in_range;
   assign w_raddr    = bus.inst_addr[DEPTH_LOG2+1:2];

   assign bus.inst         = w_served ? r_mem[w_raddr] : NOP_INST;
   assign bus.ld_ready     = w_load;
   assign bus.ld_done      = r_done;
   assign bus.words_loaded = r_wptr;
   assign bus.overflow     = r_overflow;
   assign bus.fetch_err    = r_fetch_err;
   assign bus.cpu_hold     = !w_run;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[w_waddr] <= w_word;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_byte_cnt  <= 2'd0;
         r_asm       <= '0;
         r_wptr      <= '0;
         r_done      <= 1'b0;
         r_overflow  <= 1'b0;
         r_fetch_err <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (bus.ld_start) begin
            r_state     <= S_LOAD;
            r_byte_cnt  <= 2'd0;
            r_asm       <= '0;
            r_wptr      <= '0;
            r_overflow  <= 1'b0;
            r_fetch_err <= 1'b0;
         end else begin
            case (r_state)
               S_LOAD: begin
                  if (w_acc) begin
                     if (w_full) begin
                        r_overflow <= 1'b1;
                     end
                     if (w_wr) begin
                        r_wptr <= r_wptr + {{DEPTH_LOG2{1'b0}}, 1'b1};
                     end
                     if (bus.ld_last) begin
                        r_state    <= S_RUN;
                        r_done     <= 1'b1;
                        r_byte_cnt <= 2'd0;
                        r_asm      <= '0;
                     end else begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_asm      <= (r_byte_cnt == 2'd3) ? 24'h00_0000 : w_word[23:0];
                     end
                  end
               end
               S_RUN: begin
                  if (bus.inst_ena && !(w_aligned && w_in_range)) begin
                     r_fetch_err <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_inst_mem_server.sv
// Bench for inst_mem_server: two instances (1024 and 4 words) share one stimulus stream and one session model.
module tb_inst_mem_server;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam int          M_IDLE = 0;
   localparam int          M_LOAD = 1;
   localparam int          M_RUN  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        st  = 1'b0;
   logic        vld = 1'b0;
   logic        lst = 1'b0;
   logic        ena = 1'b0;
   logic [7:0]  byt = 8'h00;
   logic [63:0] addr = 64'h0;

   int n_chk  = 0;
   int n_pass = 0;

   inst_mem_server_if #(.DEPTH_LOG2(10)) if_b ();
   inst_mem_server_if #(.DEPTH_LOG2(2))  if_s ();

   assign if_b.ld_start  = st;
   assign if_b.ld_valid  = vld;
   assign if_b.ld_byte   = byt;
   assign if_b.ld_last   = lst;
   assign if_b.inst_ena  = ena;
   assign if_b.inst_addr = addr;
   assign if_s.ld_start  = st;
   assign if_s.ld_valid  = vld;
   assign if_s.ld_byte   = byt;
   assign if_s.ld_last   = lst;
   assign if_s.inst_ena  = ena;
   assign if_s.inst_addr = addr;

   inst_mem_server #(.DEPTH_LOG2(10), .NOP_INST(NOP)) u_big   (.clk(clk), .rst(rst), .bus(if_b));
   inst_mem_server #(.DEPTH_LOG2(2),  .NOP_INST(NOP)) u_small (.clk(clk), .rst(rst), .bus(if_s));

   always #5 clk = ~clk;

   // Session model: the byte stream of the current load, and per-instance memory image.
   int          m_mode;
   bit          m_done;
   logic [7:0]  q[$];
   int          m_wl [2];
   bit          m_ov [2];
   bit          m_fe [2];
   logic [31:0] m_mem[2][1024];
   bit          m_vl [2][1024];

   function automatic int dep(input int k);
      return (k == 0) ? 10 : 2;
   endfunction

   function automatic logic [31:0] pack(input int idx);
      logic [31:0] w = 32'h0;
      for (int j = 0; j < 4; j++) begin
         if (4 * idx + j < q.size()) w[8*j +: 8] = q[4 * idx + j];
      end
      return w;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      m_done = 1'b0;
      q.delete();
      for (int k = 0; k < 2; k++) begin
         m_wl[k] = 0; m_ov[k] = 1'b0; m_fe[k] = 1'b0;
      end
   endtask

   task automatic model_step();
      bit nd = 1'b0;
      if (st) begin
         m_mode = M_LOAD;
         q.delete();
         for (int k = 0; k < 2; k++) begin
            m_wl[k] = 0; m_ov[k] = 1'b0; m_fe[k] = 1'b0;
         end
      end else if (m_mode == M_LOAD && vld) begin
         int n;
         q.push_back(byt);
         n = q.size();
         for (int k = 0; k < 2; k++) begin
            int cap = 1 << dep(k);
            int idx = (n - 1) / 4;
            if (idx < cap && (n % 4 == 0 || lst)) begin
               m_mem[k][idx] = pack(idx);
               m_vl[k][idx]  = 1'b1;
            end
            if (n > 4 * cap) m_ov[k] = 1'b1;
            if (lst) m_wl[k] = ((n + 3) / 4 < cap) ? (n + 3) / 4 : cap;
            else     m_wl[k] = (n / 4 < cap) ? n / 4 : cap;
         end
         if (lst) begin
            m_mode = M_RUN;
            nd = 1'b1;
            q.delete();
         end
      end else if (m_mode == M_RUN && ena) begin
         for (int k = 0; k < 2; k++) begin
            if (addr[1:0] != 2'b00 || (addr >> (dep(k) + 2)) != 64'h0) m_fe[k] = 1'b1;
         end
      end
      m_done = nd;
   endtask

   task automatic cmp_dut(input int k, input logic [31:0] inst, input logic rdy, input logic done,
                          input logic [10:0] wl, input logic ov, input logic fe, input logic hold);
      string p = (k == 0) ? "big" : "small";
      int    d = dep(k);
      chk({p, ".ld_ready"}, rdy, (m_mode == M_LOAD));
      chk({p, ".ld_done"}, done, m_done);
      chk({p, ".words_loaded"}, wl, m_wl[k]);
      chk({p, ".overflow"}, ov, m_ov[k]);
      chk({p, ".fetch_err"}, fe, m_fe[k]);
      chk({p, ".cpu_hold"}, hold, (m_mode != M_RUN));
      if (m_mode == M_RUN && ena && addr[1:0] == 2'b00 && (addr >> (d + 2)) == 64'h0) begin
         int idx = int'(addr >> 2);
         if (m_vl[k][idx]) chk({p, ".inst"}, inst, m_mem[k][idx]);
      end else begin
         chk({p, ".inst_nop"}, inst, NOP);
      end
   endtask

   task automatic cmp_all();
      cmp_dut(0, if_b.inst, if_b.ld_ready, if_b.ld_done, if_b.words_loaded,
              if_b.overflow, if_b.fetch_err, if_b.cpu_hold);
      cmp_dut(1, if_s.inst, if_s.ld_ready, if_s.ld_done, {8'h00, if_s.words_loaded},
              if_s.overflow, if_s.fetch_err, if_s.cpu_hold);
   endtask

   task automatic tick();
      @(negedge clk);
      cmp_all();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      st = 1'b0; vld = 1'b0; lst = 1'b0; ena = 1'b0;
      rst = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      cmp_all();
      rst = 1'b1;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic start();
      st = 1'b1; tick(); st = 1'b0;
   endtask

   task automatic send(input logic [7:0] b[$], input bit with_last);
      foreach (b[i]) begin
         vld = 1'b1; byt = b[i]; lst = with_last && (i == b.size() - 1);
         tick();
      end
      vld = 1'b0; lst = 1'b0;
   endtask

   task automatic rd(input string nm, input int k, input logic [63:0] a, input logic [31:0] exp);
      addr = a; ena = 1'b1;
      #1;
      chk(nm, (k == 0) ? if_b.inst : if_s.inst, exp);
      tick();
   endtask

   typedef struct {
      logic [63:0] a;
      logic        en;
      logic [31:0] inst;
      logic        err;
   } vec_t;

   vec_t        vt[6];
   logic [7:0]  bq[$];

   initial begin
      vt[0] = '{64'h0,    1'b1, 32'h0000_0013, 1'b0};
      vt[1] = '{64'h4,    1'b1, 32'h0010_0093, 1'b0};
      vt[2] = '{64'h0,    1'b0, NOP,           1'b0};
      vt[3] = '{64'h1000, 1'b1, NOP,           1'b1};
      vt[4] = '{64'h2,    1'b1, NOP,           1'b1};
      vt[5] = '{64'h4,    1'b0, NOP,           1'b1};

      do_reset();
      chk("rst_cpu_hold", if_b.cpu_hold, 1'b1);
      chk("rst_ld_ready", if_b.ld_ready, 1'b0);

      // Two-word image, then table of fetch vectors against the large instance.
      start();
      bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      send(bq, 1'b1);
      chk("t1_ld_done", if_b.ld_done, 1'b1);
      chk("t1_words_loaded", if_b.words_loaded, 11'd2);
      rd("t1_addr0", 0, 64'h0, 32'h0000_0013);
      chk("t1_ld_done_once", if_b.ld_done, 1'b0);
      foreach (vt[i]) begin
         addr = vt[i].a; ena = vt[i].en;
         #1;
         chk($sformatf("vec%0d_inst", i), if_b.inst, vt[i].inst);
         chk($sformatf("vec%0d_hold", i), if_b.cpu_hold, 1'b0);
         tick();
         chk($sformatf("vec%0d_err", i), if_b.fetch_err, vt[i].err);
      end

      // Reload from RUN: hold and NOP from the next cycle, fetch_err cleared.
      addr = 64'h4; ena = 1'b1;
      start();
      chk("reload_hold", if_b.cpu_hold, 1'b1);
      chk("reload_err_clr", if_b.fetch_err, 1'b0);
      chk("reload_nop", if_b.inst, NOP);
      bq = '{8'hAA, 8'hBB};
      send(bq, 1'b1);
      chk("t2_words_loaded", if_b.words_loaded, 11'd1);
      rd("t2_addr0", 0, 64'h0, 32'h0000_BBAA);

      // Restart coincident with a byte drops the byte.
      start();
      bq = '{8'h11, 8'h22, 8'h33, 8'h44};
      send(bq, 1'b0);
      chk("t3_wl_before", if_b.words_loaded, 11'd1);
      st = 1'b1; vld = 1'b1; byt = 8'h55; tick(); st = 1'b0; vld = 1'b0;
      chk("t3_wl_restart", if_b.words_loaded, 11'd0);
      bq = '{8'h01, 8'h02};
      send(bq, 1'b1);
      rd("t3_addr0", 0, 64'h0, 32'h0000_0201);

      // 20 bytes into a 4-word array.
      start();
      bq.delete();
      for (int i = 0; i < 20; i++) bq.push_back(8'(8'h10 + i));
      send(bq, 1'b1);
      chk("ov_small_wl", if_s.words_loaded, 3'd4);
      chk("ov_small_flag", if_s.overflow, 1'b1);
      chk("ov_small_done", if_s.ld_done, 1'b1);
      chk("ov_big_wl", if_b.words_loaded, 11'd5);
      chk("ov_big_flag", if_b.overflow, 1'b0);
      rd("ov_small_w0", 1, 64'h0, 32'h1312_1110);
      rd("ov_small_w3", 1, 64'hC, 32'h1F1E_1D1C);
      rd("ov_big_w4", 0, 64'h10, 32'h2322_2120);
      chk("ov_small_range_err", if_s.fetch_err, 1'b1);

      // Reset in the middle of a load, then a clean reload.
      ena = 1'b0;
      start();
      bq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      send(bq, 1'b0);
      do_reset();
      chk("mid_rst_hold", if_b.cpu_hold, 1'b1);
      chk("mid_rst_wl", if_b.words_loaded, 11'd0);
      chk("mid_rst_ready", if_b.ld_ready, 1'b0);
      start();
      bq = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
      send(bq, 1'b1);
      rd("mid_rst_w0", 0, 64'h0, 32'hC3C2_C1C0);
      rd("mid_rst_w1", 0, 64'h4, 32'hC7C6_C5C4);

      // Randomized traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            st  = ($urandom_range(0, 39) == 0);
            vld = 1'($urandom_range(0, 1));
            lst = ($urandom_range(0, 11) == 0);
            byt = 8'($urandom);
            ena = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) addr = {$urandom, $urandom};
            else addr = 64'($urandom_range(0, 47));
            tick();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
